// File: rtl/rainbow_pkg.sv
// Shared definitions for the rainbow sequencer: segment codes, duty sources
// and the segment-to-channel source table.
package rainbow_pkg;

  localparam int CNT_W = 25;

  localparam logic [2:0] SEG_R2Y = 3'd0;
  localparam logic [2:0] SEG_Y2G = 3'd1;
  localparam logic [2:0] SEG_G2C = 3'd2;
  localparam logic [2:0] SEG_C2B = 3'd3;
  localparam logic [2:0] SEG_B2M = 3'd4;
  localparam logic [2:0] SEG_M2R = 3'd5;

  typedef enum logic [1:0] {SRC_OFF, SRC_FULL, SRC_RISE, SRC_FALL} duty_src_e;

  typedef struct packed {
    duty_src_e r;
    duty_src_e g;
    duty_src_e b;
  } seg_src_t;

  // Codes 6 and 7 fall through to all-off so a corrupted segment stays dark.
  function automatic seg_src_t segSources(input logic [2:0] seg);
    seg_src_t s;
    s = '{r: SRC_OFF, g: SRC_OFF, b: SRC_OFF};
    case (seg)
      SEG_R2Y: s = '{r: SRC_FULL, g: SRC_RISE, b: SRC_OFF};
      SEG_Y2G: s = '{r: SRC_FALL, g: SRC_FULL, b: SRC_OFF};
      SEG_G2C: s = '{r: SRC_OFF,  g: SRC_FULL, b: SRC_RISE};
      SEG_C2B: s = '{r: SRC_OFF,  g: SRC_FALL, b: SRC_FULL};
      SEG_B2M: s = '{r: SRC_RISE, g: SRC_OFF,  b: SRC_FULL};
      SEG_M2R: s = '{r: SRC_FULL, g: SRC_OFF,  b: SRC_FALL};
      default: s = '{r: SRC_OFF,  g: SRC_OFF,  b: SRC_OFF};
    endcase
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] srcDuty(input duty_src_e src,
                                               input logic [CNT_W-1:0] ramp,
                                               input logic [CNT_W-1:0] period);
    logic [CNT_W-1:0] d;
    case (src)
      SRC_FULL: d = period;
      SRC_RISE: d = ramp;
      SRC_FALL: d = period - ramp;
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: latches its duty at the period end and compares it against
// the shared period counter, producing a registered, polarity-adjusted pin.
module pwm_channel
  import rainbow_pkg::*;
#(
  parameter logic ACTIVE_LOW = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             pend_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pin_o
);

  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pin_q, pin_d;

  // The compare uses the duty already latched, so a new duty only appears
  // from the first count of the following period.
  always_comb begin
    duty_d = duty_q;
    if (pend_i) duty_d = duty_i;
    pin_d = (cnt_i < duty_q) ^ ACTIVE_LOW;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      duty_q <= '0;
      pin_q  <= ACTIVE_LOW;
    end else begin
      duty_q <= duty_d;
      pin_q  <= pin_d;
    end
  end

  assign pin_o = pin_q;

endmodule

// File: rtl/rainbow_sequencer.sv
// Colour-wheel sequencer: shared PWM period counter, ramp step counter and the
// six-segment hue machine feeding three PWM channels.
module rainbow_sequencer
  import rainbow_pkg::*;
#(
  parameter int unsigned PERIOD       = 2400,
  parameter int unsigned STEP_PERIODS = 1,
  parameter logic        ACTIVE_LOW   = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  output logic       LED_R,
  output logic       LED_G,
  output logic       LED_B,
  output logic [2:0] SEG,
  output logic       PERIOD_TICK
);

  localparam logic [CNT_W-1:0] PERIOD_V  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
  localparam logic [15:0]      STEP_LAST = 16'(STEP_PERIODS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      step_q, step_d;
  logic [CNT_W-1:0] r_q, r_d;
  logic [2:0]       seg_q, seg_d;
  logic             tick_q, tick_d;

  logic             pend;
  logic             stick;
  seg_src_t         srcs;
  logic [CNT_W-1:0] dutyR, dutyG, dutyB;

  assign pend  = (cnt_q == CNT_LAST);
  assign stick = pend && EN && (step_q == STEP_LAST);

  // Counter, step and hue update; an illegal segment code recovers to red.
  always_comb begin
    cnt_d  = pend ? '0 : cnt_q + 1'b1;
    tick_d = pend;
    step_d = step_q;
    r_d    = r_q;
    seg_d  = seg_q;
    if (pend && EN) step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
    if (stick) begin
      if (seg_q > SEG_M2R) begin
        seg_d = SEG_R2Y;
        r_d   = '0;
      end else if (r_q == CNT_LAST) begin
        r_d   = '0;
        seg_d = (seg_q == SEG_M2R) ? SEG_R2Y : seg_q + 3'd1;
      end else begin
        r_d = r_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      step_q <= '0;
      r_q    <= '0;
      seg_q  <= SEG_R2Y;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      r_q    <= r_d;
      seg_q  <= seg_d;
      tick_q <= tick_d;
    end
  end

  assign srcs  = segSources(seg_q);
  assign dutyR = srcDuty(srcs.r, r_q, PERIOD_V);
  assign dutyG = srcDuty(srcs.g, r_q, PERIOD_V);
  assign dutyB = srcDuty(srcs.b, r_q, PERIOD_V);

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) chanR (
    .clk_i(CLK), .rst_i(RST), .pend_i(pend), .cnt_i(cnt_q), .duty_i(dutyR), .pin_o(LED_R)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) chanG (
    .clk_i(CLK), .rst_i(RST), .pend_i(pend), .cnt_i(cnt_q), .duty_i(dutyG), .pin_o(LED_G)
  );

  pwm_channel #(.ACTIVE_LOW(ACTIVE_LOW)) chanB (
    .clk_i(CLK), .rst_i(RST), .pend_i(pend), .cnt_i(cnt_q), .duty_i(dutyB), .pin_o(LED_B)
  );

  assign SEG         = seg_q;
  assign PERIOD_TICK = tick_q;

endmodule
